// File: rtl/led_trail_pwm.sv
// Eight-channel LED trail driver: pattern bits load full brightness and
// cleared bits either fade one level per prescaler tick or switch off at once.
module led_trail_pwm #(
   parameter int PWM_BITS  = 4,
   parameter int DECAY_DIV = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pattern,
   input  logic       en,
   input  logic       trail_en,
   output logic [7:0] led,
   output logic       busy
);

   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [15:0]         PRE_LAST = 16'(DECAY_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [15:0]         prescaler;
   logic                tick;
   logic [PWM_BITS-1:0] level [8];
   logic [7:0]          level_nz;

   always_comb begin
      tick = (prescaler == PRE_LAST);
      level_nz = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         level_nz[i] = (level[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pwm_cnt   <= '0;
         prescaler <= '0;
         led       <= '0;
         busy      <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) begin
            level[i] <= '0;
         end
      end else begin
         // led and busy are computed from the levels as they stood before this edge
         busy <= |level_nz;
         for (int unsigned i = 0; i < 8; i++) begin
            led[i] <= en & ((level[i] == MAX) | (level[i] > pwm_cnt));
         end
         if (en) begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            prescaler <= tick ? '0 : prescaler + 16'd1;
            for (int unsigned i = 0; i < 8; i++) begin
               if (pattern[i]) begin
                  level[i] <= MAX;
               end else if (!trail_en) begin
                  level[i] <= '0;
               end else if (tick && level_nz[i]) begin
                  level[i] <= level[i] - 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: reset, fade timing, hard-off, freeze,
// reload on tick and PWM duty at a mid level.
module tb_led_trail_pwm;

   logic       clk;
   logic       reset, en, trail_en;
   logic [7:0] pattern;
   logic [7:0] led;
   logic       busy;

   logic       reset2, en2, trail2;
   logic [7:0] pattern2;
   logic [7:0] led2, led3;
   logic       busy2, busy3;

   int total = 0;
   int bad   = 0;
   int hi_cnt;

   led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(4)) dut (
      .clk(clk), .reset(reset), .pattern(pattern), .en(en),
      .trail_en(trail_en), .led(led), .busy(busy));

   // a 16-cycle decay interval holds one level for exactly one PWM period
   led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(16)) dut2 (
      .clk(clk), .reset(reset2), .pattern(pattern2), .en(en2),
      .trail_en(trail2), .led(led2), .busy(busy2));

   led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(65535)) dut3 (
      .clk(clk), .reset(reset2), .pattern(pattern2), .en(en2),
      .trail_en(trail2), .led(led3), .busy(busy3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // level after edge n of a fade loaded at edge 1, decrementing every div edges
   function automatic int lev(input int n, input int div);
      int v;
      if (n <= 0) return 0;
      v = 15 - n / div;
      return (v < 0) ? 0 : v;
   endfunction

   function automatic logic exp_led(input int n, input int div);
      int l;
      l = lev(n - 1, div);
      return (l == 15) || (l > ((n - 1) % 16));
   endfunction

   initial begin
      reset = 1'b0; en = 1'b1; trail_en = 1'b1; pattern = 8'hFF;
      reset2 = 1'b0; en2 = 1'b1; trail2 = 1'b1; pattern2 = 8'h00;

      // reset overrides en and pattern
      step(); step();
      chk("rst_led", 32'(led), 32'h00);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_pwm", 32'(dut.pwm_cnt), 32'h0);
      chk("rst_pre", 32'(dut.prescaler), 32'h0);
      chk("rst_lvl", 32'(dut.level[5]), 32'h0);

      // fade with trail on, channel 0
      reset = 1'b1; pattern = 8'h01;
      step();
      chk("fade_lvl1", 32'(dut.level[0]), 32'd15);
      chk("fade_led1", 32'(led[0]), 32'(exp_led(1, 4)));
      chk("fade_busy1", 32'(busy), 32'h0);
      pattern = 8'h00;
      for (int n = 2; n <= 70; n++) begin
         step();
         chk($sformatf("fade_lvl%0d", n), 32'(dut.level[0]), 32'(lev(n, 4)));
         chk($sformatf("fade_led%0d", n), 32'(led[0]), 32'(exp_led(n, 4)));
         chk($sformatf("fade_busy%0d", n), 32'(busy), 32'(lev(n - 1, 4) != 0));
      end

      // hard off with trail disabled, channel 7
      trail_en = 1'b0; pattern = 8'h80;
      step();
      chk("hard_lvl_load", 32'(dut.level[7]), 32'd15);
      chk("hard_led_load", 32'(led), 32'h00);
      chk("hard_busy_load", 32'(busy), 32'h0);
      pattern = 8'h00;
      step();
      chk("hard_lvl_clr", 32'(dut.level[7]), 32'd0);
      chk("hard_led_clr", 32'(led), 32'h80);
      chk("hard_busy_clr", 32'(busy), 32'h1);
      step();
      chk("hard_led_off", 32'(led), 32'h00);
      chk("hard_busy_off", 32'(busy), 32'h0);

      // freeze mid-fade at level 9
      reset = 1'b0; trail_en = 1'b1;
      step();
      reset = 1'b1; pattern = 8'h01;
      step();
      pattern = 8'h00;
      for (int n = 2; n <= 25; n++) step();
      chk("frz_lvl_pre", 32'(dut.level[0]), 32'd9);
      en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("frz_led", 32'(led), 32'h00);
         chk("frz_lvl", 32'(dut.level[0]), 32'd9);
         chk("frz_pwm", 32'(dut.pwm_cnt), 32'd9);
         chk("frz_pre", 32'(dut.prescaler), 32'd1);
      end
      en = 1'b1;
      for (int n = 26; n <= 40; n++) begin
         step();
         chk($sformatf("res_lvl%0d", n), 32'(dut.level[0]), 32'(lev(n, 4)));
         chk($sformatf("res_led%0d", n), 32'(led[0]), 32'(exp_led(n, 4)));
      end

      // reload on a tick edge, channel 3
      reset = 1'b0;
      step();
      reset = 1'b1; pattern = 8'h08;
      step();
      pattern = 8'h00;
      for (int n = 2; n <= 43; n++) step();
      chk("rld_lvl_pre", 32'(dut.level[3]), 32'd5);
      chk("rld_pre_tick", 32'(dut.prescaler), 32'd3);
      pattern = 8'h08;
      step();
      chk("rld_lvl_tick", 32'(dut.level[3]), 32'd15);
      pattern = 8'h00;
      step(); step(); step();
      chk("rld_lvl_hold", 32'(dut.level[3]), 32'd15);
      step();
      chk("rld_lvl_dec", 32'(dut.level[3]), 32'd14);

      // duty at level 8 over one full PWM period, channel 2
      reset2 = 1'b1; pattern2 = 8'h04;
      step();
      pattern2 = 8'h00;
      for (int n = 2; n <= 112; n++) step();
      chk("duty_lvl", 32'(dut2.level[2]), 32'd8);
      hi_cnt = 0;
      for (int n = 113; n <= 128; n++) begin
         step();
         if (led2[2]) hi_cnt++;
         chk($sformatf("duty_led%0d", n), 32'(led2[2]), 32'(n <= 120));
      end
      chk("duty_count", 32'(hi_cnt), 32'd8);
      chk("big_div_lvl", 32'(dut3.level[2]), 32'd15);
      chk("big_div_led", 32'(led3), 32'h04);
      chk("big_div_busy", 32'(busy3), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
